// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline memory stage placed after execute.
// Runs scalar (1 beat) and vector (BEATS beats) transfers over a 32-bit
// req/ack bus and produces one registered writeback bundle per register file.
// The single vector write port is shared between convolution writes (always
// first), vector loads and vector ALU pass-through.
// Optional build macro: MEM_ALIGN_CHK_EN -- misaligned memory operations are
// trapped (mem_err pulse, no bus request, no writeback) instead of having
// address bits [1:0] masked to zero.
module mem_access_stage #(
  parameter int VBYTES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          in_rD,
  input  logic [31:0]         in_s_result,
  input  logic [VBYTES*8-1:0] in_v_result,
  input  logic [31:0]         in_s_write,
  input  logic [VBYTES*8-1:0] in_v_write,
  input  logic                in_ldr,
  input  logic [1:0]          in_wb,
  input  logic                in_mem_rw,
  input  logic                in_mem_v,
  input  logic [VBYTES*8-1:0] conv_result,
  input  logic [4:0]          conv_addr,
  input  logic                conv_write,
  output logic                stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  input  logic                mem_ack,
`ifdef MEM_ALIGN_CHK_EN
  output logic                mem_err,
`endif
  output logic                s_wb_en,
  output logic [4:0]          s_wb_rD,
  output logic [31:0]         s_wb_data,
  output logic                v_wb_en,
  output logic [4:0]          v_wb_rD,
  output logic [VBYTES*8-1:0] v_wb_data
);

  localparam int VW    = VBYTES * 8;
  localparam int BEATS = VBYTES / 4;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  // Select 32-bit beat idx of a vector (beat 0 = least significant word).
  function automatic logic [31:0] get_word(input logic [VW-1:0] data,
                                           input logic [BW-1:0] idx);
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < BEATS; i++) begin
      w = (idx == BW'(i)) ? data[32*i +: 32] : w;
    end
    return w;
  endfunction

  // Replace 32-bit beat idx of a vector with word.
  function automatic logic [VW-1:0] put_word(input logic [VW-1:0] data,
                                             input logic [BW-1:0] idx,
                                             input logic [31:0]   word);
    logic [VW-1:0] r;
    r = data;
    for (int i = 0; i < BEATS; i++) begin
      r[32*i +: 32] = (idx == BW'(i)) ? word : r[32*i +: 32];
    end
    return r;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [4:0]    rd_q, rd_d;
  logic          ldr_q, ldr_d;
  logic          vec_q, vec_d;
  logic [VW-1:0] store_q, store_d;
  logic [VW-1:0] ldbuf_q, ldbuf_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          s_wb_en_q, s_wb_en_d;
  logic [4:0]    s_wb_rd_q, s_wb_rd_d;
  logic [31:0]   s_wb_data_q, s_wb_data_d;
  logic          v_wb_en_q, v_wb_en_d;
  logic [4:0]    v_wb_rd_q, v_wb_rd_d;
  logic [VW-1:0] v_wb_data_q, v_wb_data_d;
`ifdef MEM_ALIGN_CHK_EN
  logic          err_q, err_d;
`endif

  logic          memop_s;
  logic          ack_s;
  logic          last_s;
  logic          stall_s;
  logic [BW-1:0] next_beat_s;
  logic [31:0]   base_addr_s;

  // Next-state, bus and writeback computation for all states.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    rd_d        = rd_q;
    ldr_d       = ldr_q;
    vec_d       = vec_q;
    store_d     = store_q;
    ldbuf_d     = ldbuf_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    s_wb_en_d   = 1'b0;
    s_wb_rd_d   = s_wb_rd_q;
    s_wb_data_d = s_wb_data_q;
    v_wb_en_d   = 1'b0;
    v_wb_rd_d   = v_wb_rd_q;
    v_wb_data_d = v_wb_data_q;
`ifdef MEM_ALIGN_CHK_EN
    err_d       = 1'b0;
`endif
    stall_s     = 1'b0;
    memop_s     = in_ldr | in_mem_rw;
    // ack is only meaningful while a request is outstanding
    ack_s       = mem_ack & mem_req_q;
    last_s      = vec_q ? (beat_q == LAST_BEAT) : 1'b1;
    next_beat_s = beat_q + BW'(1'b1);
    // word-aligned base; low bits are either trapped or ignored
    base_addr_s = in_s_result & 32'hFFFF_FFFC;

    case (state_q)
      ST_IDLE: begin
        if (memop_s) begin
`ifdef MEM_ALIGN_CHK_EN
          if (err_q) begin
            // faulting op was reported last cycle; drop it and let upstream move on
            stall_s = 1'b0;
          end else if (in_s_result[1:0] != 2'b00) begin
            stall_s = 1'b1;
            err_d   = 1'b1;
          end else begin
`endif
            stall_s     = 1'b1;
            state_d     = ST_ACCESS;
            beat_d      = {BW{1'b0}};
            rd_d        = in_rD;
            ldr_d       = in_ldr;
            vec_d       = in_mem_v;
            store_d     = in_mem_v ? in_v_write : VW'(in_s_write);
            ldbuf_d     = {VW{1'b0}};
            mem_req_d   = 1'b1;
            mem_we_d    = in_mem_rw & ~in_ldr;
            mem_addr_d  = base_addr_s;
            mem_wdata_d = in_mem_v ? in_v_write[31:0] : in_s_write;
`ifdef MEM_ALIGN_CHK_EN
          end
`endif
        end else begin
          if (in_wb == 2'b01) begin
            s_wb_en_d   = 1'b1;
            s_wb_rd_d   = in_rD;
            s_wb_data_d = in_s_result;
          end else begin
            s_wb_en_d = 1'b0;
          end
          if (in_wb == 2'b10) begin
            if (conv_write) begin
              // port taken by the convolution write; retry next cycle
              stall_s = 1'b1;
            end else begin
              v_wb_en_d   = 1'b1;
              v_wb_rd_d   = in_rD;
              v_wb_data_d = in_v_result;
            end
          end else begin
            v_wb_en_d = 1'b0;
          end
        end
      end
      ST_ACCESS: begin
        if (ack_s) begin
          if (ldr_q) begin
            ldbuf_d = put_word(ldbuf_q, beat_q, mem_rdata);
          end else begin
            ldbuf_d = ldbuf_q;
          end
          if (last_s) begin
            stall_s   = 1'b0;
            state_d   = ST_IDLE;
            beat_d    = {BW{1'b0}};
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            if (ldr_q && vec_q) begin
              if (conv_write) begin
                state_d = ST_HOLD;
              end else begin
                v_wb_en_d   = 1'b1;
                v_wb_rd_d   = rd_q;
                v_wb_data_d = ldbuf_d;
              end
            end else if (ldr_q) begin
              s_wb_en_d   = 1'b1;
              s_wb_rd_d   = rd_q;
              s_wb_data_d = mem_rdata;
            end else begin
              s_wb_en_d = 1'b0;
            end
          end else begin
            stall_s     = 1'b1;
            beat_d      = next_beat_s;
            mem_addr_d  = mem_addr_q + 32'd4;
            mem_wdata_d = get_word(store_q, next_beat_s);
          end
        end else begin
          stall_s = 1'b1;
        end
      end
      ST_HOLD: begin
        stall_s = 1'b1;
        if (conv_write) begin
          state_d = ST_HOLD;
        end else begin
          state_d     = ST_IDLE;
          v_wb_en_d   = 1'b1;
          v_wb_rd_d   = rd_q;
          v_wb_data_d = ldbuf_q;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase

    // convolution results own the vector port whenever they arrive
    if (conv_write) begin
      v_wb_en_d   = 1'b1;
      v_wb_rd_d   = conv_addr;
      v_wb_data_d = conv_result;
    end else begin
      v_wb_en_d = v_wb_en_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      beat_q      <= {BW{1'b0}};
      rd_q        <= 5'd0;
      ldr_q       <= 1'b0;
      vec_q       <= 1'b0;
      store_q     <= {VW{1'b0}};
      ldbuf_q     <= {VW{1'b0}};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      s_wb_en_q   <= 1'b0;
      s_wb_rd_q   <= 5'd0;
      s_wb_data_q <= 32'd0;
      v_wb_en_q   <= 1'b0;
      v_wb_rd_q   <= 5'd0;
      v_wb_data_q <= {VW{1'b0}};
`ifdef MEM_ALIGN_CHK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      rd_q        <= rd_d;
      ldr_q       <= ldr_d;
      vec_q       <= vec_d;
      store_q     <= store_d;
      ldbuf_q     <= ldbuf_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      s_wb_en_q   <= s_wb_en_d;
      s_wb_rd_q   <= s_wb_rd_d;
      s_wb_data_q <= s_wb_data_d;
      v_wb_en_q   <= v_wb_en_d;
      v_wb_rd_q   <= v_wb_rd_d;
      v_wb_data_q <= v_wb_data_d;
`ifdef MEM_ALIGN_CHK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign stall     = stall_s;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign s_wb_en   = s_wb_en_q;
  assign s_wb_rD   = s_wb_rd_q;
  assign s_wb_data = s_wb_data_q;
  assign v_wb_en   = v_wb_en_q;
  assign v_wb_rD   = v_wb_rd_q;
  assign v_wb_data = v_wb_data_q;
`ifdef MEM_ALIGN_CHK_EN
  assign mem_err   = err_q;
`endif

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline memory stage sitting directly after the execute stage. It consumes the execute outputs: ALU results, store data, load/store/writeback controls, and the convolution result write. It performs scalar and vector data-memory transactions over a 32-bit request/acknowledge bus. It presents one registered writeback bundle to the register files, arbitrating the single vector-register write port between convolution results and loads or ALU results.

## Interface
Parameters:
- VBYTES, 16: vector width in bytes; must equal `LENGTH`; must be a multiple of 4.
- BEATS, VBYTES/4: 32-bit beats per vector transfer (derived, not overridable).

Ports:
- clk  in  1: clock; all state updates on rising edge.
- reset  in  1: synchronous, active-high.
- in_rD  in  5: destination register.
- in_s_result  in  32: scalar ALU result; doubles as the memory byte address.
- in_v_result  in  VBYTES*8: vector ALU result.
- in_s_write  in  32: scalar store data.
- in_v_write  in  VBYTES*8: vector store data.
- in_ldr  in  1: load.
- in_wb  in  2: 00 none, 01 scalar reg, 10 vector reg, 11 reserved (treated as 00).
- in_mem_rw  in  1: 1 = store; ignored when in_ldr=1.
- in_mem_v  in  1: memory operation is a vector transfer.
- conv_result  in  VBYTES*8; conv_addr  in  5; conv_write  in  1: convolution vector write request.
- stall  out  1: combinational; upstream holds all inputs while high.
- mem_req  out  1; mem_we  out  1; mem_addr  out  32; mem_wdata  out  32; mem_rdata  in  32; mem_ack  in  1.
- s_wb_en  out  1; s_wb_rD  out  5; s_wb_data  out  32.
- v_wb_en  out  1; v_wb_rD  out  5; v_wb_data  out  VBYTES*8.
- mem_err  out  1: present only with MEM_ALIGN_CHK_EN.

## Operation
- Memory op (memop) = in_ldr | in_mem_rw. Vector iff in_mem_v.
- States:
  - IDLE: no transfer in progress.
  - ACCESS: transfer in progress; beat counter 0..BEATS-1; scalar transfers use 1 beat.
  - HOLD: one-cycle deferral of a vector writeback.
- IDLE with memop: latch all inputs, set beat=0, go to ACCESS.
- IDLE without memop: pass-through.
  - in_wb=01: s_wb registered from in_s_result.
  - in_wb=10: v_wb registered from in_v_result.
- Memory bus in ACCESS:
  - mem_req=1.
  - mem_addr = base + 4*beat.
  - mem_we = latched mem_rw & ~ldr.
  - mem_wdata = store data bits [32*beat+31 : 32*beat] (little-endian beat order).
  - mem_req, mem_addr, mem_we and mem_wdata stay stable until mem_ack is sampled.
  - mem_ack is ignored while mem_req=0.
- On each sampled ack:
  - Loads capture mem_rdata into byte lane group beat.
  - beat increments.
  - On the last beat, a store returns to IDLE.
  - On the last beat, a load returns to IDLE and writes back to s_wb (scalar) or v_wb (vector).
- Vector port arbitration:
  - conv_write has absolute priority and is registered to v_wb (v_wb_rD = conv_addr) in every state.
  - A vector load completing in the same cycle as conv_write goes to HOLD, then writes on the next cycle.
  - A vector pass-through colliding with conv_write raises stall for that cycle and is retried.
- stall = (IDLE & memop) | (ACCESS & ~(mem_ack & last beat)) | HOLD | (IDLE & in_wb==10 & conv_write & ~memop).
- Reset values: state=IDLE, beat=0, and every output 0 (mem_req, mem_we, mem_addr, mem_wdata, all wb signals, mem_err).
- Reset mid-transfer: mem_req drops after the reset edge, captured data is discarded, and no writeback occurs.

## Timing
- Pass-through: wb valid 1 cycle after the input cycle.
- Scalar access with ack in the first cycle of mem_req:
  - Accept edge E0; mem_req high during E0..E1; ack sampled at E1.
  - Scalar load: s_wb_en high for exactly one cycle after E1, so latency is 2 cycles.
  - Store: stall low in the cycle before E1.
- Vector access with 0-wait ack: 1+BEATS cycles; each wait cycle adds 1.
- HOLD adds exactly 1 cycle.
- s_wb_en and v_wb_en are single-cycle pulses; both may be high in the same cycle.

## Configuration
- MEM_ALIGN_CHK_EN defined:
  - Scalar or vector memop with in_s_result[1:0]≠0: no bus request, stall high for 1 cycle, mem_err pulses 1 cycle, no writeback.
- MEM_ALIGN_CHK_EN undefined:
  - Address bits [1:0] are forced to 0 on mem_addr.
  - mem_err port is absent.

## Test plan
- Scalar load: in_ldr=1, addr 0x40, wb=01, rD=3; ack next cycle with rdata 0xDEADBEEF -> s_wb_en pulse 2 cycles after accept, s_wb_rD=3, data 0xDEADBEEF.
- Vector store with VBYTES=16: addr 0x100, 2-cycle ack delay on beat 1 -> mem_addr sequence 0x100, 0x104, 0x108, 0x10C; wdata beats in little-endian order; no writeback; stall low before the last ack edge.
- Vector load finishing in the same cycle as conv_write (conv_addr=16) -> v_wb carries the conv result (rD 16) first, then the load result on the next cycle; the state passes through HOLD.
- Pass-through: wb=10 plus conv_write in the same cycle -> stall high 1 cycle, conv written first, ALU result the next cycle.
- Reset asserted on beat 2 of a 4-beat load -> mem_req=0 after the reset edge; no v_wb_en pulse ever occurs for that load.
- MEM_ALIGN_CHK_EN: load at address 0x42 -> no mem_req; mem_err pulses 1 cycle.
